// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Recovers the hex value shown on a multiplexed, active-low 7-segment display
// by snooping its segment and anode lines. Each {anode, segment} sample is
// registered once. It must then stay unchanged for STABLE_CYCLES consecutive
// cycles before it is accepted as a digit. Accepted digits are decoded into a
// shadow frame. Once every digit position has been seen, the frame is handed
// to the consumer through a valid/ready output register. If the consumer
// still holds an unaccepted frame, the new frame is dropped and an overrun
// pulse is raised. Acquisition never stalls.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits
//   STABLE_CYCLES  consecutive identical samples needed for a capture (>= 1)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   inp_seg        active-low segments, bit6 = g ... bit0 = a
//   inp_anode      active-low digit select, bit0 = least-significant digit
//   inp_ready      consumer accepts out_value
//   out_value      decoded frame, digit k in bits [4k+3:4k]
//   out_digit_err  per-digit invalid-pattern flags of the presented frame
//   out_valid      out_value / out_digit_err hold a frame
//   out_overrun    one-cycle pulse when a completed frame is dropped
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              inp_seg,
   input  logic [NUM_DIGITS-1:0]   inp_anode,
   input  logic                    inp_ready,
   output logic [4*NUM_DIGITS-1:0] out_value,
   output logic [NUM_DIGITS-1:0]   out_digit_err,
   output logic                    out_valid,
   output logic                    out_overrun
);

   localparam int SAMP_W   = NUM_DIGITS + 7;
   localparam int STABLE_N = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
   localparam int CNT_W    = $clog2(STABLE_N + 1);

   // The counter saturates at CNT_MAX. A capture fires on the single step
   // from CNT_ARM to CNT_MAX, so a long stable interval yields one capture.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_N);
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_N - 1);

   typedef enum logic [0:0] {
      ST_ACQ = 1'b0,   // collecting digits into the shadow frame
      ST_OVR = 1'b1    // a completed frame was just dropped
   } state_t;

   // Returns {err, nibble}. Unknown patterns (including blank) give nibble 0.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'b1000000: res = {1'b0, 4'h0};
         7'b1111001: res = {1'b0, 4'h1};
         7'b0100100: res = {1'b0, 4'h2};
         7'b0110000: res = {1'b0, 4'h3};
         7'b0011001: res = {1'b0, 4'h4};
         7'b0010010: res = {1'b0, 4'h5};
         7'b0000010: res = {1'b0, 4'h6};
         7'b1111000: res = {1'b0, 4'h7};
         7'b0000000: res = {1'b0, 4'h8};
         7'b0010000: res = {1'b0, 4'h9};
         7'b0001000: res = {1'b0, 4'hA};
         7'b0000011: res = {1'b0, 4'hB};
         7'b0100111: res = {1'b0, 4'hC};
         7'b0100001: res = {1'b0, 4'hD};
         7'b0000110: res = {1'b0, 4'hE};
         7'b0001110: res = {1'b0, 4'hF};
         default:    res = {1'b1, 4'h0};
      endcase
      return res;
   endfunction

   // True when exactly one bit of the (active-high) select mask is set.
   function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] sel);
      return (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [SAMP_W-1:0]       samp_p0_q, samp_p0_d;   // registered input sample
   logic [SAMP_W-1:0]       samp_p1_q, samp_p1_d;   // previous registered sample
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic [4*NUM_DIGITS-1:0] out_value_q, out_value_d;
   logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
   logic                    out_valid_q, out_valid_d;
   state_t                  state_q, state_d;

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] reg_anode;
   logic [6:0]            reg_seg;
   logic [NUM_DIGITS-1:0] sel_mask;
   logic                  sample_same;
   logic                  capture;
   logic [4:0]            dec;
   logic                  frame_done;
   logic                  frame_load;
   logic                  frame_drop;
   logic                  overrun;

   // ---------------------------------------------------------------------------
   // Stage p0/p1: input register and stability counter
   // ---------------------------------------------------------------------------
   always_comb begin
      samp_p0_d   = {inp_anode, inp_seg};
      samp_p1_d   = samp_p0_q;
      reg_anode   = samp_p0_q[SAMP_W-1:7];
      reg_seg     = samp_p0_q[6:0];
      sel_mask    = ~reg_anode;
      sample_same = (samp_p0_q == samp_p1_q);

      cnt_d = cnt_q;
      if (!sample_same) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // No capture for idle (no digit) or ghosting (several digits) selects.
      capture = sample_same && (cnt_q == CNT_ARM) && is_onehot(sel_mask);
      dec     = decode_seg(reg_seg);
   end

   // ---------------------------------------------------------------------------
   // Shadow frame and capture mask
   // ---------------------------------------------------------------------------
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_err_d = shadow_err_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (capture && sel_mask[k]) begin
            shadow_val_d[4*k +: 4] = dec[3:0];
            shadow_err_d[k]        = dec[4];
         end
      end

      // A completed frame always empties the mask, whether it is loaded or
      // dropped. A capture landing on that same edge already belongs to the
      // next frame.
      mask_d = frame_done ? '0 : mask_q;
      if (capture) begin
         mask_d = mask_d | sel_mask;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = ST_ACQ;
      if (frame_drop) begin
         state_d = ST_OVR;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and frame hand-off decisions
   // ---------------------------------------------------------------------------
   always_comb begin
      frame_done = &mask_q;
      frame_load = frame_done && (!out_valid_q || inp_ready);
      frame_drop = frame_done && out_valid_q && !inp_ready;
      overrun    = (state_q == ST_OVR);
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   always_comb begin
      out_value_d = out_value_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      if (frame_load) begin
         out_value_d = shadow_val_q;
         out_err_d   = shadow_err_q;
         out_valid_d = 1'b1;
      end else if (out_valid_q && inp_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register and all other flops
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp_p0_q    <= '0;
         samp_p1_q    <= '0;
         cnt_q        <= '0;
         shadow_val_q <= '0;
         shadow_err_q <= '0;
         mask_q       <= '0;
         out_value_q  <= '0;
         out_err_q    <= '0;
         out_valid_q  <= 1'b0;
         state_q      <= ST_ACQ;
      end else begin
         samp_p0_q    <= samp_p0_d;
         samp_p1_q    <= samp_p1_d;
         cnt_q        <= cnt_d;
         shadow_val_q <= shadow_val_d;
         shadow_err_q <= shadow_err_d;
         mask_q       <= mask_d;
         out_value_q  <= out_value_d;
         out_err_q    <= out_err_d;
         out_valid_q  <= out_valid_d;
         state_q      <= state_d;
      end
   end

   assign out_value     = out_value_q;
   assign out_digit_err = out_err_q;
   assign out_valid     = out_valid_q;
   assign out_overrun   = overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// A table of complete frames is scanned and compared, and hand-written
// sequences cover glitches, bad anodes, backpressure and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 4;

   // Segment patterns for hex 0..F (active low, bit6 = g ... bit0 = a).
   localparam logic [6:0] PAT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] JUNK  = 7'b0101010;

   typedef struct packed {
      logic [3:0][6:0] seg;       // seg[k] = pattern shown on digit k
      logic [15:0]     exp_val;
      logic [3:0]      exp_err;
   } vec_t;

   logic              clk;
   logic              reset;
   logic [6:0]        inp_seg;
   logic [ND-1:0]     inp_anode;
   logic              inp_ready;
   logic [4*ND-1:0]   out_value;
   logic [ND-1:0]     out_digit_err;
   logic              out_valid;
   logic              out_overrun;

   int          checks;
   int          failures;
   int          vcount;
   int          ocount;
   int          hold_bad;
   logic        hold_on;
   logic [15:0] hold_val;
   logic [15:0] last_val;
   logic [3:0]  last_err;
   vec_t        vecs [6];

   seg7_scan_decoder #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .inp_seg       (inp_seg),
      .inp_anode     (inp_anode),
      .inp_ready     (inp_ready),
      .out_value     (out_value),
      .out_digit_err (out_digit_err),
      .out_valid     (out_valid),
      .out_overrun   (out_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock; outputs are observed 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
         vcount++;
         last_val = out_value;
         last_err = out_digit_err;
         if (hold_on && out_value !== hold_val) hold_bad++;
      end
      if (out_overrun === 1'b1) ocount++;
   endtask

   task automatic drive_digit(input int k, input logic [6:0] p);
      inp_anode = ~(4'b0001 << k);
      inp_seg   = p;
      repeat (8) step();
   endtask

   task automatic idle(input int n);
      inp_anode = 4'b1111;
      inp_seg   = BLANK;
      repeat (n) step();
   endtask

   task automatic clr_counts();
      vcount   = 0;
      ocount   = 0;
      hold_bad = 0;
      last_val = '0;
      last_err = '0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      hold_on   = 1'b0;
      hold_val  = '0;
      clr_counts();

      // Table: digit order 0..3, value nibble k is digit k.
      vecs[0].seg = {PAT[4],  PAT[3],  PAT[2],  PAT[1]};  vecs[0].exp_val = 16'h4321; vecs[0].exp_err = 4'b0000;
      vecs[1].seg = {PAT[8],  PAT[7],  PAT[6],  PAT[5]};  vecs[1].exp_val = 16'h8765; vecs[1].exp_err = 4'b0000;
      vecs[2].seg = {PAT[12], PAT[11], PAT[10], PAT[9]};  vecs[2].exp_val = 16'hCBA9; vecs[2].exp_err = 4'b0000;
      vecs[3].seg = {PAT[0],  PAT[15], PAT[14], PAT[13]}; vecs[3].exp_val = 16'h0FED; vecs[3].exp_err = 4'b0000;
      vecs[4].seg = {PAT[4],  BLANK,   PAT[2],  PAT[1]};  vecs[4].exp_val = 16'h4021; vecs[4].exp_err = 4'b0100;
      vecs[5].seg = {PAT[8],  PAT[0],  PAT[15], JUNK};    vecs[5].exp_val = 16'h80F0; vecs[5].exp_err = 4'b0001;

      reset     = 1'b1;
      inp_anode = 4'b1111;
      inp_seg   = BLANK;
      inp_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_value",   32'(out_value),     32'h0);
      chk("rst_err",     32'(out_digit_err), 32'h0);
      chk("rst_valid",   32'(out_valid),     32'h0);
      chk("rst_overrun", 32'(out_overrun),   32'h0);
      @(posedge clk);
      #2 reset = 1'b0;

      // Glitch: digit0 held only 3 cycles must not be captured
      clr_counts();
      inp_anode = 4'b1110;
      inp_seg   = PAT[8];
      repeat (3) step();
      drive_digit(1, PAT[2]);
      drive_digit(2, PAT[3]);
      drive_digit(3, PAT[4]);
      idle(10);
      chk("glitch_no_frame", 32'(vcount), 32'd0);
      drive_digit(0, PAT[1]);
      idle(6);
      chk("glitch_frame_cnt", 32'(vcount), 32'd1);
      chk("glitch_frame_val", 32'(last_val), 32'h4321);

      // Invalid anodes: no digit selected, then two digits selected
      clr_counts();
      inp_anode = 4'b1111;
      inp_seg   = PAT[1];
      repeat (10) step();
      inp_anode = 4'b1100;
      repeat (10) step();
      chk("bad_anode_no_valid", 32'(vcount), 32'd0);
      drive_digit(1, PAT[5]);
      drive_digit(2, PAT[6]);
      drive_digit(3, PAT[7]);
      idle(10);
      chk("bad_anode_no_frame", 32'(vcount), 32'd0);
      drive_digit(0, PAT[8]);
      idle(6);
      chk("bad_anode_frame_val", 32'(last_val), 32'h7658);

      // Table-driven frames with inp_ready=1: each frame valid for one cycle
      for (int i = 0; i < 6; i++) begin
         clr_counts();
         for (int k = 0; k < 4; k++) drive_digit(k, vecs[i].seg[k]);
         idle(6);
         chk($sformatf("vec%0d_valid_cycles", i), 32'(vcount),   32'd1);
         chk($sformatf("vec%0d_value", i),        32'(last_val), 32'(vecs[i].exp_val));
         chk($sformatf("vec%0d_err", i),          32'(last_err), 32'(vecs[i].exp_err));
      end

      // Backpressure: second frame dropped, outputs held, one overrun pulse
      clr_counts();
      inp_ready = 1'b0;
      for (int k = 0; k < 4; k++) drive_digit(k, vecs[0].seg[k]);
      idle(6);
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      chk("bp_first_value", 32'(out_value), 32'h4321);
      hold_val = 16'h4321;
      hold_on  = 1'b1;
      for (int k = 0; k < 4; k++) drive_digit(k, vecs[1].seg[k]);
      idle(6);
      chk("bp_overrun_pulses", 32'(ocount),   32'd1);
      chk("bp_value_stable",   32'(hold_bad), 32'd0);
      chk("bp_value_held",     32'(out_value), 32'h4321);
      inp_ready = 1'b1;
      step();
      chk("bp_valid_drop", 32'(out_valid), 32'd0);
      hold_on = 1'b0;

      // Mid-frame asynchronous reset
      clr_counts();
      inp_ready = 1'b0;
      for (int k = 0; k < 4; k++) drive_digit(k, vecs[0].seg[k]);
      idle(6);
      chk("mr_pre_valid", 32'(out_valid), 32'd1);
      drive_digit(0, PAT[5]);
      drive_digit(1, PAT[6]);
      #3;
      reset     = 1'b1;
      inp_anode = 4'b1111;
      inp_seg   = BLANK;
      #1;
      chk("mr_value",   32'(out_value),     32'h0);
      chk("mr_err",     32'(out_digit_err), 32'h0);
      chk("mr_valid",   32'(out_valid),     32'h0);
      chk("mr_overrun", 32'(out_overrun),   32'h0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      inp_ready = 1'b1;
      clr_counts();
      drive_digit(2, PAT[7]);
      drive_digit(3, PAT[8]);
      idle(10);
      chk("mr_partial_lost", 32'(vcount), 32'd0);
      drive_digit(0, PAT[9]);
      drive_digit(1, PAT[10]);
      idle(6);
      chk("mr_frame_cnt", 32'(vcount),   32'd1);
      chk("mr_frame_val", 32'(last_val), 32'h87A9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples required before a digit is captured (minimum 1).
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 inp_seg  input  7  active-low segment pattern, bit6=g ... bit0=a.
REQ-006 inp_anode  input  NUM_DIGITS  active-low digit select; bit0 is the least-significant digit.
REQ-007 inp_ready  input  1  consumer accepts out_value.
REQ-008 out_value  output  4*NUM_DIGITS  decoded hex value; digit k occupies bits [4k+3:4k].
REQ-009 out_digit_err  output  NUM_DIGITS  per-digit invalid-pattern flags for the presented frame.
REQ-010 out_valid  output  1  frame in out_value/out_digit_err is valid.
REQ-011 out_overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL register {inp_anode, inp_seg} in one input stage before any other use.
REQ-013 SHALL count consecutive cycles in which the registered sample equals the previous registered sample, and restart the count on any difference.
REQ-014 SHALL capture a digit exactly once per stable interval, when the stable count reaches STABLE_CYCLES and the registered anode has exactly one bit low.
REQ-015 SHALL NOT capture when the registered anode has no bits low or more than one bit low.
REQ-016 Capture latency: the capture SHALL occur 1+STABLE_CYCLES cycles after a new {anode, seg} value is first presented.
REQ-017 SHALL decode the following patterns: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=B, 0100111=C, 0100001=D, 0000110=E, 0001110=F.
REQ-018 Any other pattern, including blank 1111111, SHALL decode to nibble 0 and set that digit's error bit.
REQ-019 A capture SHALL write the decoded nibble and error bit into the shadow slot of the selected digit and set that digit's bit in the capture mask.
REQ-020 Recapturing a digit before the frame completes SHALL overwrite its shadow slot.
REQ-021 FSM: ACQ collects digits; when all mask bits are set, a frame is complete.
REQ-022 On frame complete with out_valid=0, or with out_valid=1 and inp_ready=1, the next cycle SHALL load shadow into out_value/out_digit_err, hold out_valid=1, and clear the mask.
REQ-023 On frame complete with out_valid=1 and inp_ready=0, the block SHALL drop the frame, clear the mask, pulse out_overrun for 1 cycle, and leave the outputs unchanged.
REQ-024 out_valid SHALL deassert on the cycle after out_valid=1 and inp_ready=1 when no new frame is loaded in that cycle.
REQ-025 out_value and out_digit_err SHALL stay stable while out_valid=1 and inp_ready=0.
REQ-026 Captures SHALL continue during backpressure; acquisition is never stalled.

Reset
REQ-027 Reset SHALL clear the input register, stable counter, shadow slots, mask and FSM (to ACQ).
REQ-028 During reset, out_value=0, out_digit_err=0, out_valid=0, out_overrun=0.
REQ-029 Reset asserted mid-frame SHALL discard partial captures; acquisition SHALL restart from an empty mask after release.

Verification
REQ-030 Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; the previous frame is lost.
REQ-031 Clean scan, NUM_DIGITS=4, STABLE_CYCLES=4, inp_ready=1: anode 1110/1101/1011/0111 with patterns 1111001/0100100/0110000/0011001, each held 8 cycles -> out_value=16'h4321, out_digit_err=0000, out_valid for 1 cycle.
REQ-032 Glitch rejection: digit0 pattern held 3 cycles, then changed -> no capture; the mask is unchanged.
REQ-033 Invalid pattern: digit2 held at 1111111, the others valid as in REQ-031 -> out_value=16'h4021, out_digit_err=0100.
REQ-034 Backpressure: inp_ready=0 for two full frames (16'h4321 then 16'h8765) -> out_value stays 16'h4321, out_overrun pulses once; raising inp_ready drops out_valid the next cycle.
REQ-035 Invalid anode: anode=1111 or 1100 held 10 cycles -> no capture; out_valid stays 0.
